// File: rtl/button_evt_pkg.sv
// Purpose: shared event encoding and width helpers for the button event decoder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   evt_type_e : 2-bit event type carried in the top bits of an event code
//   clog2      : ceiling log2 used to size counters and index fields
//   cw         : clog2 clamped to at least 1 bit, for register widths
package button_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_type_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cw(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// Purpose: one button channel: 2-FF synchroniser, polarity fix, debounce, pulse generation.
// Latency: pin edge to level_o/press_o/release_o = 2 + DEBOUNCE_CYCLES cycles;
//   long_o fires LONG_CYCLES cycles after press_o.
// Backpressure: none; pulses are single-cycle and never wait.
//
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   pin_i          raw asynchronous button pin
//   level_o        debounced pressed state, 1 = pressed
//   press_o        1-cycle pulse on level rise
//   release_o      1-cycle pulse on level fall
//   long_o         1-cycle pulse once per press after LONG_CYCLES held
module button_debounce_ch
  import button_evt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int   DW   = cw(DEBOUNCE_CYCLES);
  localparam int   LW   = cw(LONG_CYCLES);
  localparam logic IDLE = (ACTIVE_LOW != 0);

  logic          meta_q, sync_q;
  logic          pressed;
  logic [DW-1:0] deb_q, deb_d;
  logic [LW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          done_q, done_d;
  logic          toggle;

  // Synchroniser resets to the idle pin value so reset never looks like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= IDLE;
      sync_q <= IDLE;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
    end
  end

  assign pressed = sync_q ^ IDLE;

  always_comb begin
    deb_d     = deb_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = hold_q;
    done_d    = done_q;
    long_d    = 1'b0;
    toggle    = 1'b0;

    // Any cycle where the synchronised value agrees with level restarts the count.
    if (pressed == level_q) begin
      deb_d = '0;
    end else if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      deb_d     = '0;
      level_d   = ~level_q;
      toggle    = 1'b1;
      press_d   = ~level_q;
      release_d = level_q;
    end else begin
      deb_d = deb_q + DW'(1);
    end

    // Hold counter saturates at LONG_CYCLES-1; done_q limits long_o to once per press.
    if (toggle && !level_q) begin
      hold_d = '0;
      done_d = 1'b0;
    end else if (level_q && !toggle) begin
      if (hold_q == LW'(LONG_CYCLES - 1)) begin
        if (!done_q) begin
          long_d = 1'b1;
          done_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      done_q    <= done_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/sync_fifo.sv
// Purpose: small generic single-clock FIFO, power-of-two depth, pointers wrap naturally.
// Latency: one cycle from push to pop_vld_o; head is visible combinationally.
// Backpressure: push ignored while full (full is registered state, so a pop in the
//   same cycle does not open a slot); head held stable until pop_rdy_i.
//
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   push_vld_i, push_dat_i   write request and data
//   full_o                   FIFO holds DEPTH entries
//   pop_rdy_i                consumer takes the head entry
//   pop_vld_o, pop_dat_o     FIFO non-empty, head entry (0 when empty)
module sync_fifo
  import button_evt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             full_o,
  input  logic             pop_rdy_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_dat_o
);

  localparam int AW  = cw(DEPTH);
  localparam int CNW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CNW-1:0]   cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (cnt_q == CNW'(DEPTH));
  assign pop_vld_o = (cnt_q != '0);
  assign do_push   = push_vld_i & ~full_o;
  assign do_pop    = pop_rdy_i & pop_vld_o;
  assign pop_dat_o = pop_vld_o ? mem_q[rd_q] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CNW'(do_push) - CNW'(do_pop);
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Purpose: debounced button levels/pulses plus an encoded event queue.
// Latency: pin edge to pulse 2+DEBOUNCE_CYCLES; pulse to evt_valid_o 2 further cycles.
// Backpressure: evt_ready_i low holds the head; when the FIFO is full events wait in
//   per-button/per-type pending bits, and a repeat of a waiting event is dropped (sticky overflow).
//
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   button_i          raw asynchronous pins
//   level_o           debounced pressed state per button
//   press_pulse_o     1-cycle pulse on level rise
//   release_pulse_o   1-cycle pulse on level fall
//   long_pulse_o      1-cycle pulse after LONG_CYCLES of continuous press
//   evt_valid_o       event queue non-empty
//   evt_ready_i       consumer accepts head entry
//   evt_code_o        {type[1:0], button index}
//   evt_overflow_o    sticky, an event was dropped
module button_event_decoder
  import button_evt_pkg::*;
#(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int ACTIVE_LOW      = 0,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_BUTTONS-1:0]            button_i,
  output logic [N_BUTTONS-1:0]            level_o,
  output logic [N_BUTTONS-1:0]            press_pulse_o,
  output logic [N_BUTTONS-1:0]            release_pulse_o,
  output logic [N_BUTTONS-1:0]            long_pulse_o,
  output logic                            evt_valid_o,
  input  logic                            evt_ready_i,
  output logic [2+clog2(N_BUTTONS)-1:0]   evt_code_o,
  output logic                            evt_overflow_o
);

  localparam int IW     = clog2(N_BUTTONS);
  localparam int CODE_W = 2 + IW;
  localparam int NP     = 3 * N_BUTTONS;

  // Pending bit layout: index 3*b + t, t = 0 press, 1 release, 2 long. Scanning
  // from bit 0 upward gives lowest button first, then press < release < long.
  logic [NP-1:0]     evt_new;
  logic [NP-1:0]     pend_q, pend_d;
  logic [NP-1:0]     grant;
  logic              ovf_q, ovf_d;
  logic              fifo_full;
  logic              push_vld;
  logic [CODE_W-1:0] push_dat;
  logic [1:0]        ty;

  for (genvar b = 0; b < N_BUTTONS; b++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pin_i     (button_i[b]),
      .level_o   (level_o[b]),
      .press_o   (press_pulse_o[b]),
      .release_o (release_pulse_o[b]),
      .long_o    (long_pulse_o[b])
    );
    assign evt_new[3*b+0] = press_pulse_o[b];
    assign evt_new[3*b+1] = release_pulse_o[b];
    assign evt_new[3*b+2] = long_pulse_o[b];
  end

  // Arbiter works only from registered pending bits and registered full; no bypass.
  always_comb begin
    grant    = '0;
    push_vld = 1'b0;
    push_dat = '0;
    ty       = EVT_NONE;
    if (!fifo_full) begin
      for (int i = 0; i < NP; i++) begin
        if (pend_q[i] && !push_vld) begin
          push_vld = 1'b1;
          grant[i] = 1'b1;
          ty       = (i % 3 == 0) ? EVT_PRESS : ((i % 3 == 1) ? EVT_RELEASE : EVT_LONG);
          push_dat = (CODE_W'(ty) << IW) | CODE_W'(i / 3);
        end
      end
    end
  end

  // A new event whose pending bit is still occupied (and not leaving) is lost.
  always_comb begin
    pend_d = (pend_q & ~grant) | evt_new;
    ovf_d  = ovf_q | (|(evt_new & pend_q & ~grant));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign evt_overflow_o = ovf_q;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_vld_i (push_vld),
    .push_dat_i (push_dat),
    .full_o     (fifo_full),
    .pop_rdy_i  (evt_ready_i),
    .pop_vld_o  (evt_valid_o),
    .pop_dat_o  (evt_code_o)
  );

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] button;
  logic [1:0] level, press_p, release_p, long_p;
  logic       evt_valid, evt_ready, evt_overflow;
  logic [2:0] evt_code;

  logic [1:0] al_button;
  logic [1:0] al_level, al_press, al_release, al_long;
  logic       al_valid, al_overflow;
  logic [2:0] al_code;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_press [2];
  int n_long  [2];
  int press_cyc0 = 0;
  int long_cyc0  = 0;
  int al_bad = 0;
  logic al_watch = 1'b1;
  int rec;

  always #5 clk = ~clk;

  button_event_decoder #(
    .N_BUTTONS(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(0), .FIFO_DEPTH(4)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .button_i(button), .level_o(level),
    .press_pulse_o(press_p), .release_pulse_o(release_p), .long_pulse_o(long_p),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_code_o(evt_code),
    .evt_overflow_o(evt_overflow)
  );

  button_event_decoder #(
    .N_BUTTONS(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1), .FIFO_DEPTH(4)
  ) u_dut_al (
    .clk_i(clk), .rst_i(rst), .button_i(al_button), .level_o(al_level),
    .press_pulse_o(al_press), .release_pulse_o(al_release), .long_pulse_o(al_long),
    .evt_valid_o(al_valid), .evt_ready_i(1'b1), .evt_code_o(al_code),
    .evt_overflow_o(al_overflow)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (press_p[b]) n_press[b] <= n_press[b] + 1;
      if (long_p[b])  n_long[b]  <= n_long[b] + 1;
    end
    if (press_p[0]) press_cyc0 <= cyc;
    if (long_p[0])  long_cyc0  <= cyc;
    if (al_watch && !rst &&
        ((al_level | al_press | al_release | al_long) != 2'b00 || al_valid || al_overflow))
      al_bad <= al_bad + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a head entry, checks it, then pops it with a 1-cycle ready.
  task automatic pop_expect(input string tag, input logic [2:0] exp);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (evt_valid === 1'b1 && evt_code === exp) else begin
      miscompares++;
      $error("FAIL %s: observed valid=%b code=%b expected valid=1 code=%b",
             tag, evt_valid, evt_code, exp);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  // Press then release with a hold well short of LONG_CYCLES.
  task automatic tap(input int b);
    button[b] = 1'b1;
    tick(10);
    button[b] = 1'b0;
    tick(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    button = 2'b00;
    al_button = 2'b11;
    evt_ready = 1'b0;
    tick(3);
    chk("rst_level", 32'(level), 0);
    chk("rst_pulses", 32'({press_p, release_p, long_p}), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code", 32'(evt_code), 0);
    chk("rst_ovf", 32'(evt_overflow), 0);
    rst = 1'b0;
    tick(2);

    // 1: bounce on button 0, then a clean hold
    for (int i = 0; i < 10; i++) begin
      button[0] = ~button[0];
      tick(2);
    end
    chk("t1_bounce_level", 32'(level), 0);
    button[0] = 1'b1;
    tick(5);
    chk("t1_level_before", 32'(level), 0);
    tick(1);
    chk("t1_level_rise", 32'(level), 32'h1);
    chk("t1_press_pulse", 32'(press_p), 32'h1);
    tick(1);
    chk("t1_press_width", 32'(press_p), 0);
    tick(1);
    chk("t1_npress", 32'(n_press[0]), 1);
    pop_expect("t1_pop_press", 3'b010);
    chk("t1_fifo_empty", 32'(evt_valid), 0);
    button[0] = 1'b0;
    pop_expect("t1_pop_release", 3'b100);
    tick(2);

    // 2: long press
    rec = n_long[0];
    button[0] = 1'b1;
    tick(30);
    button[0] = 1'b0;
    tick(15);
    chk("t2_long_delay", 32'(long_cyc0 - press_cyc0), 20);
    chk("t2_long_once", 32'(n_long[0] - rec), 1);
    pop_expect("t2_pop_press", 3'b010);
    pop_expect("t2_pop_long", 3'b110);
    pop_expect("t2_pop_release", 3'b100);
    tick(2);
    chk("t2_empty", 32'(evt_valid), 0);

    // 3: simultaneous press
    button = 2'b11;
    tick(6);
    chk("t3_press_both", 32'(press_p), 32'h3);
    tick(2);
    chk("t3_first_head", 32'({evt_valid, evt_code}), 32'b1010);
    pop_expect("t3_pop_b0", 3'b010);
    pop_expect("t3_pop_b1", 3'b011);
    button = 2'b00;
    pop_expect("t3_pop_rel_b0", 3'b100);
    pop_expect("t3_pop_rel_b1", 3'b101);
    tick(2);

    // 4: backpressure, pending, overflow
    tap(0);
    tap(1);
    chk("t4_full_head", 32'({evt_valid, evt_code}), 32'b1010);
    button[0] = 1'b1;
    tick(10);
    chk("t4_stable_code", 32'(evt_code), 32'b010);
    chk("t4_no_ovf_yet", 32'(evt_overflow), 0);
    button[0] = 1'b0;
    tick(10);
    chk("t4_no_ovf_release", 32'(evt_overflow), 0);
    button[0] = 1'b1;
    tick(10);
    chk("t4_ovf_set", 32'(evt_overflow), 1);
    chk("t4_stable_code2", 32'(evt_code), 32'b010);
    button[0] = 1'b0;
    tick(10);
    pop_expect("t4_d0", 3'b010);
    pop_expect("t4_d1", 3'b100);
    pop_expect("t4_d2", 3'b011);
    pop_expect("t4_d3", 3'b101);
    pop_expect("t4_d4_pending", 3'b010);
    pop_expect("t4_d5_pending", 3'b100);
    tick(3);
    chk("t4_drained", 32'(evt_valid), 0);
    chk("t4_ovf_sticky", 32'(evt_overflow), 1);

    // 5: reset in the middle of a debounce count
    button[1] = 1'b1;
    tick(9);
    chk("t5_pre_valid", 32'(evt_valid), 1);
    button[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    chk("t5_rst_level", 32'(level), 0);
    chk("t5_rst_valid", 32'(evt_valid), 0);
    chk("t5_rst_code", 32'(evt_code), 0);
    chk("t5_rst_ovf", 32'(evt_overflow), 0);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("t5_level_before", 32'(level), 0);
    tick(1);
    chk("t5_level_rise", 32'(level), 32'h3);
    button = 2'b00;
    pop_expect("t5_pop_b0", 3'b010);
    pop_expect("t5_pop_b1", 3'b011);
    pop_expect("t5_pop_rel_b0", 3'b100);
    pop_expect("t5_pop_rel_b1", 3'b101);

    // 6: active-low instance with pins idle high
    tick(1000);
    chk("t6_idle_quiet", 32'(al_bad), 0);
    al_watch = 1'b0;
    al_button[1] = 1'b0;
    tick(5);
    chk("t6_al_before", 32'(al_level), 0);
    tick(1);
    chk("t6_al_press", 32'(al_level), 32'h2);
    al_button[1] = 1'b1;
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
